nb_arbiter: RTL and testbench

NB_ARBITER -- requirements
Module: nb_arbiter

---
 rtl/nb_arbiter.sv | 153 +++++++++++++++
 tb/tb_nb_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// nb_arbiter - round-robin arbiter of two requesters onto one memory port (rev 1.0)
// -----------------------------------------------------------------------------
module nb_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  s0_cs,
  input  logic                  s0_we,
  input  logic                  s0_re,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [DATA_WIDTH-1:0] s0_wdata,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_ready,
  output logic                  s0_err,
  input  logic                  s1_cs,
  input  logic                  s1_we,
  input  logic                  s1_re,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [DATA_WIDTH-1:0] s1_wdata,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_ready,
  output logic                  s1_err,
  output logic                  m_cs,
  output logic                  m_we,
  output logic                  m_re,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int         WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  ptr_q, ptr_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

  logic                  w_req0, w_req1;
  logic                  w_sel_we, w_sel_rd;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_req0      = s0_cs & (s0_we | s0_re);
  assign w_req1      = s1_cs & (s1_we | s1_re);
  // Write wins when a requester raises both we and re.
  assign w_sel_we    = grant_q ? s1_we : s0_we;
  assign w_sel_rd    = (grant_q ? s1_re : s0_re) & ~w_sel_we;
  assign w_sel_addr  = grant_q ? s1_addr : s0_addr;
  assign w_sel_wdata = grant_q ? s1_wdata : s0_wdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      ptr_q    <= 1'b0;
      wait_q   <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      wait_q   <= wait_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    wait_d   = wait_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (w_req0 | w_req1) begin
          grant_d = (w_req0 & w_req1) ? ptr_q : w_req1;
          wait_d  = '0;
          err_d   = 1'b0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        wait_d = wait_q + 1'b1;
        // A completion arriving in the timeout cycle still counts as normal.
        if (m_ready) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          if (w_sel_rd) begin
            if (grant_q) rdata1_d = m_rdata;
            else         rdata0_d = m_rdata;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = ~grant_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m_cs     = 1'b0;
    m_we     = 1'b0;
    m_re     = 1'b0;
    m_addr   = '0;
    m_wdata  = '0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    s0_err   = 1'b0;
    s1_err   = 1'b0;
    if (state_q == S_BUSY) begin
      m_cs    = 1'b1;
      m_we    = w_sel_we;
      m_re    = w_sel_rd;
      m_addr  = w_sel_addr;
      m_wdata = w_sel_wdata;
    end
    if (state_q == S_RESP) begin
      s0_ready = ~grant_q;
      s1_ready = grant_q;
      s0_err   = ~grant_q & err_q;
      s1_err   = grant_q & err_q;
    end
  end

  assign s0_rdata = rdata0_q;
  assign s1_rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_nb_arbiter.sv
`default_nettype none
// tb_nb_arbiter - directed vector table plus hand-written contention/timeout/reset sequences.
module tb_nb_arbiter;

  logic       clk = 1'b0;
  logic       resetn;
  logic       s0_cs, s0_we, s0_re, s1_cs, s1_we, s1_re;
  logic [7:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
  logic [7:0] s0_rdata, s1_rdata;
  logic       s0_ready, s0_err, s1_ready, s1_err;
  logic       m_cs, m_we, m_re, m_ready;
  logic [7:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nb_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .resetn(resetn),
    .s0_cs(s0_cs), .s0_we(s0_we), .s0_re(s0_re), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_rdata(s0_rdata), .s0_ready(s0_ready), .s0_err(s0_err),
    .s1_cs(s1_cs), .s1_we(s1_we), .s1_re(s1_re), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_rdata(s1_rdata), .s1_ready(s1_ready), .s1_err(s1_err),
    .m_cs(m_cs), .m_we(m_we), .m_re(m_re), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  // Memory model: m_ready in the mem_lat-th consecutive m_cs cycle; mem_lat=0 never answers.
  logic [7:0] mem [256] = '{default: 8'h00};
  int         busy_cnt = 0;
  int         mem_lat  = 3;

  always_ff @(posedge clk) begin
    if (m_cs) busy_cnt <= busy_cnt + 1;
    else      busy_cnt <= 0;
    if (m_cs && m_ready && m_we) mem[m_addr] <= m_wdata;
  end
  assign m_ready = m_cs && (mem_lat != 0) && (busy_cnt == mem_lat - 1);
  assign m_rdata = mem[m_addr];

  typedef struct {
    bit         port;
    bit         we;
    bit         re;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit cs, input bit we, input bit re,
                         input logic [7:0] addr, input logic [7:0] wdata);
    if (port) begin
      s1_cs = cs; s1_we = we; s1_re = re; s1_addr = addr; s1_wdata = wdata;
    end else begin
      s0_cs = cs; s0_we = we; s0_re = re; s0_addr = addr; s0_wdata = wdata;
    end
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge of the following idle cycle.
  task automatic do_txn(input bit port, input bit we, input bit re, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp_rdata, input bit exp_err,
                        input int exp_lat, input int exp_mcs, input string nm);
    int lat = 0, mcs = 0, other = 0;
    bit got = 0, act_err = 0, seen_we = 0, seen_re = 0;
    set_req(port, 1'b1, we, re, addr, wdata);
    while (!got && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (m_cs) begin
        if (mcs == 0) begin seen_we = m_we; seen_re = m_re; end
        mcs++;
      end
      if (port ? (s0_ready | s0_err) : (s1_ready | s1_err)) other++;
      if (port ? s1_ready : s0_ready) begin
        got = 1;
        act_err = port ? s1_err : s0_err;
      end
    end
    set_req(port, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk({nm, "_done"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, lat, exp_lat);
    chk({nm, "_mcs"}, mcs, exp_mcs);
    chk({nm, "_err"}, 32'(act_err), 32'(exp_err));
    chk({nm, "_other"}, other, 0);
    chk({nm, "_mwe"}, 32'(seen_we), 32'(we));
    chk({nm, "_mre"}, 32'(seen_re), 32'(re & ~we));
    chk({nm, "_rdata"}, port ? s1_rdata : s0_rdata, exp_rdata);
    if (we && !exp_err) chk({nm, "_mem"}, mem[addr], wdata);
    @(posedge clk); @(negedge clk);
    chk({nm, "_idle"}, {m_cs, s0_ready, s1_ready, s0_err, s1_err}, 5'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int cyc;
    int pulse_port[3];
    int pulse_cyc[3];
    logic [7:0] pulse_data[3];

    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h20, 8'h3C, 8'hA5};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'h20, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'h30, 8'h5A, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'h30, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 8'h3C};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 8'hFF};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h01};

    resetn = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_mport", {m_cs, m_we, m_re}, 3'b000);
    chk("rst_flags", {s0_ready, s1_ready, s0_err, s1_err}, 4'b0000);
    chk("rst_rdata", {s0_rdata, s1_rdata}, 16'h0000);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++)
      do_txn(vecs[i].port, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_rdata, 1'b0, 4, 3, $sformatf("v%0d", i));

    // Completion in the very cycle the timeout would fire: normal completion.
    mem_lat = 15;
    do_txn(1'b1, 1'b0, 1'b1, 8'h20, 8'h00, 8'h3C, 1'b0, 16, 15, "edge_ready");
    // Memory never answers: error completion after 15 BUSY cycles, rdata untouched.
    mem_lat = 0;
    do_txn(1'b0, 1'b0, 1'b1, 8'h10, 8'h00, 8'h01, 1'b1, 16, 15, "timeout");

    // Reset while BUSY; pointer is at port 1 here, so contention afterwards proves it reset.
    mem_lat = 3;
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("midrst_busy", 32'(m_cs), 32'd1);
    resetn = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    set_req(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
    @(posedge clk); @(negedge clk);
    chk("midrst_mport", {m_cs, m_we, m_re}, 3'b000);
    chk("midrst_flags", {s0_ready, s1_ready, s0_err, s1_err}, 4'b0000);
    chk("midrst_rdata", {s0_rdata, s1_rdata}, 16'h0000);
    @(posedge clk); @(negedge clk);
    chk("midrst_hold", {m_cs, s0_ready, s1_ready}, 3'b000);

    // Both requesting at reset exit, held: expect 0, 1, 0 at 5-cycle spacing.
    resetn = 1'b1;
    pulses = 0;
    cyc = 0;
    while (pulses < 3 && cyc < 60) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (s0_ready && s1_ready) chk("cont_both", 32'd1, 32'd0);
      if (s0_ready || s1_ready) begin
        pulse_port[pulses] = s1_ready ? 1 : 0;
        pulse_cyc[pulses]  = cyc;
        pulse_data[pulses] = s1_ready ? s1_rdata : s0_rdata;
        pulses++;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("cont_count", pulses, 3);
    if (pulses == 3) begin
      chk("cont_order0", pulse_port[0], 0);
      chk("cont_order1", pulse_port[1], 1);
      chk("cont_order2", pulse_port[2], 0);
      chk("cont_cyc0", pulse_cyc[0], 4);
      chk("cont_cyc1", pulse_cyc[1], 9);
      chk("cont_cyc2", pulse_cyc[2], 14);
      chk("cont_data", {pulse_data[0], pulse_data[1], pulse_data[2]}, 24'hA5A5A5);
    end
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("final_idle", {m_cs, s0_ready, s1_ready, s0_err, s1_err}, 5'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
